// File: rtl/pre_if_stage_pkg.sv
// Shared widths, reset PC, branch bus layout and pre-IF state encoding.
// Imported by pre_if_stage (mycpu.h equivalents).
package pre_if_stage_pkg;

   localparam logic [31:0] RESET_PC = 32'h1c000000;
   localparam int PFS_TO_FS_BUS_WD = 65;
   localparam int BR_BUS_WD = 35;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2,
      ST_DROP = 2'd3
   } pfs_state_e;

   typedef struct packed {
      logic        taken;
      logic        taken_cancel;
      logic        stall;
      logic [31:0] target;
   } br_bus_t;

endpackage

// File: rtl/pre_if_stage.sv
// Pre-IF stage: fetch PC generation, inst SRAM request channel, response
// buffering and redirect handling; hands {inst_valid, inst, pc} to IF.
// Ports: clk/reset, IF handshake (fs_allowin, fs_block), br_bus from ID,
// WB flushes (wb_exc/wb_ertn + ex_entry/ertn_pc), pfs_to_fs_valid/bus,
// inst SRAM req/wr/size/addr/wstrb/wdata, addr_ok/data_ok/rdata.
module pre_if_stage
   import pre_if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC_P = RESET_PC
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        fs_allowin,
   input  logic                        fs_block,
   input  logic [BR_BUS_WD-1:0]        br_bus,
   input  logic                        wb_exc,
   input  logic                        wb_ertn,
   input  logic [31:0]                 ex_entry,
   input  logic [31:0]                 ertn_pc,
   output logic                        pfs_to_fs_valid,
   output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
   output logic                        inst_sram_req,
   output logic                        inst_sram_wr,
   output logic [1:0]                  inst_sram_size,
   output logic [31:0]                 inst_sram_addr,
   output logic [3:0]                  inst_sram_wstrb,
   output logic [31:0]                 inst_sram_wdata,
   input  logic                        inst_sram_addr_ok,
   input  logic                        inst_sram_data_ok,
   input  logic [31:0]                 inst_sram_rdata
);

   pfs_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_buf_q, inst_buf_d;
   logic        pfs_valid_q;

   br_bus_t     br;
   logic        unused_br_cancel;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        own_data;
   logic        hs;
   logic        xfer;
   logic        ready_go;
   logic        inst_valid;
   logic [31:0] inst;

   assign br = br_bus_t'(br_bus);
   assign unused_br_cancel = br.taken_cancel;

   assign redirect = wb_exc | wb_ertn | (br.taken & ~br.stall);
   assign redirect_pc = wb_exc  ? ex_entry :
                        wb_ertn ? ertn_pc  :
                                  br.target;

   // Only a data_ok that arrives while IF is not waiting belongs here.
   assign own_data = inst_sram_data_ok & fs_block;
   assign hs       = inst_sram_req & inst_sram_addr_ok;
   assign xfer     = pfs_to_fs_valid & fs_allowin;

   always_comb begin
      ready_go      = 1'b0;
      inst_sram_req = 1'b0;
      unique case (state_q)
         ST_REQ: begin
            inst_sram_req = ~reset & pfs_valid_q & ~br.stall & ~redirect;
            ready_go      = hs;
         end
         ST_WAIT: ready_go = 1'b1;
         ST_DONE: ready_go = 1'b1;
         ST_DROP: ready_go = 1'b0;
         default: ready_go = 1'b0;
      endcase
   end

   assign pfs_to_fs_valid = ~reset & pfs_valid_q & ready_go & ~redirect;

   assign inst_valid = (state_q == ST_DONE) |
                       ((state_q == ST_WAIT) & own_data);
   assign inst       = (state_q == ST_DONE) ? inst_buf_q : inst_sram_rdata;

   assign pfs_to_fs_bus = {inst_valid, inst, pc_q};

   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_addr  = pc_q;
   assign inst_sram_wstrb = 4'b0000;
   assign inst_sram_wdata = 32'h0;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_buf_d = inst_buf_q;
      unique case (state_q)
         ST_REQ: begin
            if (redirect) begin
               pc_d = redirect_pc;
            end else if (hs & xfer) begin
               pc_d = pc_q + 32'd4;
            end else if (hs) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               // Without our data yet, the stale response must be eaten.
               state_d = own_data ? ST_REQ : ST_DROP;
            end else if (xfer) begin
               pc_d    = pc_q + 32'd4;
               state_d = ST_REQ;
            end else if (own_data) begin
               inst_buf_d = inst_sram_rdata;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = ST_REQ;
            end else if (xfer) begin
               pc_d    = pc_q + 32'd4;
               state_d = ST_REQ;
            end
         end
         ST_DROP: begin
            if (redirect) begin
               pc_d = redirect_pc;
            end
            if (own_data) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_REQ;
         pc_q        <= RESET_PC_P;
         inst_buf_q  <= 32'h0;
         pfs_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_buf_q  <= inst_buf_d;
         pfs_valid_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage: fetch handshake, buffering,
// redirect priority, drop of stale responses, stall and wrap.
module tb_pre_if_stage;
   import pre_if_stage_pkg::*;

   logic        clk;
   logic        reset;
   logic        fs_allowin;
   logic        fs_block;
   logic [34:0] br_bus;
   logic        wb_exc;
   logic        wb_ertn;
   logic [31:0] ex_entry;
   logic [31:0] ertn_pc;
   logic        pfs_to_fs_valid;
   logic [64:0] pfs_to_fs_bus;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   int checks;
   int errors;

   pre_if_stage dut (
      .clk               (clk),
      .reset             (reset),
      .fs_allowin        (fs_allowin),
      .fs_block          (fs_block),
      .br_bus            (br_bus),
      .wb_exc            (wb_exc),
      .wb_ertn           (wb_ertn),
      .ex_entry          (ex_entry),
      .ertn_pc           (ertn_pc),
      .pfs_to_fs_valid   (pfs_to_fs_valid),
      .pfs_to_fs_bus     (pfs_to_fs_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [64:0] got,
                        input logic [64:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fs_allowin        = 1'b0;
      fs_block          = 1'b0;
      br_bus            = 35'h0;
      wb_exc            = 1'b0;
      wb_ertn           = 1'b0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      ex_entry = 32'h0;
      ertn_pc  = 32'h0;
      inst_sram_rdata = 32'h0;
      idle();
      tick();
      tick();
      inst_sram_addr_ok = 1'b1;
      fs_allowin = 1'b1;
      #1;
      check("rst_valid", 65'(pfs_to_fs_valid), 65'd0);
      check("rst_req", 65'(inst_sram_req), 65'd0);
      check("rst_addr", 65'(inst_sram_addr), 65'h1c000000);
      check("const_size", 65'(inst_sram_size), 65'd2);
      check("const_wr", 65'({inst_sram_wr, inst_sram_wstrb,
                             inst_sram_wdata}), 65'd0);
      reset = 1'b0;
      #1;
      // pfs_valid still 0 in the first cycle after release
      check("c0_req", 65'(inst_sram_req), 65'd0);
      tick();
      // C1: hs + xfer, inst_valid=0
      check("c1_req", 65'(inst_sram_req), 65'd1);
      check("c1_valid", 65'(pfs_to_fs_valid), 65'd1);
      check("c1_bus", pfs_to_fs_bus, {1'b0, 32'h0, 32'h1c000000});
      tick();
      // C2: hs without xfer -> WAIT
      fs_allowin = 1'b0;
      #1;
      check("c2_addr", 65'(inst_sram_addr), 65'h1c000004);
      check("c2_req", 65'(inst_sram_req), 65'd1);
      tick();
      // C3: WAIT, no data
      idle();
      #1;
      check("c3_req", 65'(inst_sram_req), 65'd0);
      check("c3_bus", {63'd0, pfs_to_fs_valid, pfs_to_fs_bus[64]},
            65'b10);
      tick();
      // C4: own data_ok while stalled -> DONE
      inst_sram_data_ok = 1'b1;
      fs_block = 1'b1;
      inst_sram_rdata = 32'h02800c21;
      #1;
      check("c4_ivalid", 65'(pfs_to_fs_bus[64]), 65'd1);
      tick();
      // C5: DONE holds buffered inst
      idle();
      inst_sram_rdata = 32'h0;
      #1;
      check("c5_bus_hold", pfs_to_fs_bus, {1'b1, 32'h02800c21,
                                           32'h1c000004});
      fs_allowin = 1'b1;
      #1;
      check("c5_valid", 65'(pfs_to_fs_valid), 65'd1);
      check("c5_bus", pfs_to_fs_bus, {1'b1, 32'h02800c21, 32'h1c000004});
      tick();
      // C6: hs without xfer -> WAIT
      idle();
      inst_sram_addr_ok = 1'b1;
      #1;
      check("c6_addr", 65'(inst_sram_addr), 65'h1c000008);
      tick();
      // C7: branch in WAIT without data -> DROP
      idle();
      br_bus = {1'b1, 1'b0, 1'b0, 32'h1c000100};
      #1;
      check("c7_valid", 65'(pfs_to_fs_valid), 65'd0);
      check("c7_req", 65'(inst_sram_req), 65'd0);
      tick();
      // C8: DROP ignores foreign data_ok
      idle();
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata = 32'hdeadbeef;
      #1;
      check("c8_req", 65'(inst_sram_req), 65'd0);
      check("c8_valid", 65'(pfs_to_fs_valid), 65'd0);
      tick();
      // C9: own stale data discarded
      fs_block = 1'b1;
      #1;
      check("c9_req", 65'(inst_sram_req), 65'd0);
      check("c9_valid", 65'(pfs_to_fs_valid), 65'd0);
      tick();
      // C10: refetch at branch target; then triple redirect
      idle();
      #1;
      check("c10_req", 65'(inst_sram_req), 65'd1);
      check("c10_addr", 65'(inst_sram_addr), 65'h1c000100);
      wb_exc = 1'b1;
      wb_ertn = 1'b1;
      ex_entry = 32'h1c008000;
      ertn_pc = 32'h1c000040;
      br_bus = {1'b1, 1'b0, 1'b0, 32'h1c000100};
      #1;
      check("c10_redir_req", 65'(inst_sram_req), 65'd0);
      tick();
      // C11: exc wins; then taken+stall is not a redirect
      idle();
      #1;
      check("c11_addr", 65'(inst_sram_addr), 65'h1c008000);
      check("c11_req", 65'(inst_sram_req), 65'd1);
      br_bus = {1'b1, 1'b0, 1'b1, 32'h1c000200};
      #1;
      check("c11_stall_req", 65'(inst_sram_req), 65'd0);
      tick();
      // C12: stall alone holds req low, pc unchanged
      idle();
      br_bus = {1'b0, 1'b0, 1'b1, 32'h0};
      #1;
      check("c12_req", 65'(inst_sram_req), 65'd0);
      check("c12_addr", 65'(inst_sram_addr), 65'h1c008000);
      tick();
      // C13: stall drops, hs without xfer -> WAIT
      idle();
      inst_sram_addr_ok = 1'b1;
      #1;
      check("c13_req", 65'(inst_sram_req), 65'd1);
      tick();
      // C14: foreign data_ok in WAIT not captured
      idle();
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata = 32'hdeadbeef;
      #1;
      check("c14_ivalid", 65'(pfs_to_fs_bus[64]), 65'd0);
      check("c14_valid", 65'(pfs_to_fs_valid), 65'd1);
      tick();
      // C15: own data passes through with xfer
      idle();
      inst_sram_data_ok = 1'b1;
      fs_block = 1'b1;
      fs_allowin = 1'b1;
      inst_sram_rdata = 32'h12345678;
      #1;
      check("c15_bus", pfs_to_fs_bus, {1'b1, 32'h12345678, 32'h1c008000});
      tick();
      // C16: ertn alone
      idle();
      #1;
      check("c16_addr", 65'(inst_sram_addr), 65'h1c008004);
      wb_ertn = 1'b1;
      ertn_pc = 32'h1c000040;
      #1;
      tick();
      // C17: ertn target; then exception to top of address space
      idle();
      #1;
      check("c17_addr", 65'(inst_sram_addr), 65'h1c000040);
      wb_exc = 1'b1;
      ex_entry = 32'hfffffffc;
      #1;
      tick();
      // C18: hs + xfer at last word wraps
      idle();
      inst_sram_addr_ok = 1'b1;
      fs_allowin = 1'b1;
      #1;
      check("c18_addr", 65'(inst_sram_addr), 65'hfffffffc);
      tick();
      idle();
      #1;
      check("c19_wrap", 65'(inst_sram_addr), 65'h0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
